// File: rtl/nesoi_video_pkg.sv
// Shared video timing types and the 640x480@60 default timing.
package nesoi_video_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/hdmi_axis_counter.sv
// One timing axis: wrapping position counter with active and sync-window decode.
module hdmi_axis_counter #(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_active,
  output logic             o_sync
);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC_START + SYNC_LEN);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else if (i_advance)
      r_count <= o_wrap ? '0 : r_count + CNT_W'(1);
  end

  assign o_count  = r_count;
  assign o_wrap   = (r_count == LAST);
  assign o_active = (r_count < ACT_END);
  assign o_sync   = (r_count >= SYNC_BEG) && (r_count < SYNC_END);

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video timing controller: h/v counters, syncs, DE and pixel pull for the HDMI encoder.
//   state    | meaning
//   IDLE     | counters held at 0, outputs inactive
//   RUN      | counting, frames emitted
//   STOPPING | finishing current frame, back to IDLE after last pixel slot
module hdmi_timing_ctrl
  import nesoi_video_pkg::*;
#(
  parameter int     H_ACTIVE      = VGA_H_ACTIVE,
  parameter int     H_FP          = VGA_H_FP,
  parameter int     H_SYNC        = VGA_H_SYNC,
  parameter int     H_BP          = VGA_H_BP,
  parameter int     V_ACTIVE      = VGA_V_ACTIVE,
  parameter int     V_FP          = VGA_V_FP,
  parameter int     V_SYNC        = VGA_V_SYNC,
  parameter int     V_BP          = VGA_V_BP,
  parameter bit     HS_POL        = 1'b0,
  parameter bit     VS_POL        = 1'b0,
  parameter pixel_t UNDERFLOW_RGB = 24'hFF00FF,
  parameter int     CNT_W         = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  pixel_t           pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             underflow_clr,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output pixel_t           rgb,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic             underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  state_t           r_state, w_state_nxt;
  logic             w_running, w_emit, w_active, w_miss;
  logic             w_h_wrap, w_h_act, w_h_sync;
  logic             w_v_wrap, w_v_act, w_v_sync;
  logic [CNT_W-1:0] w_h, w_v;

  logic             r_hsync, r_vsync, r_de, r_fs, r_underflow;
  pixel_t           r_rgb;
  logic [CNT_W-1:0] r_x, r_y;

  assign w_running = (r_state != IDLE);

  hdmi_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .CNT_W(CNT_W)
  ) u_h_cnt (
    .clk(clk), .rst(rst), .i_clear(!w_running), .i_advance(w_running),
    .o_count(w_h), .o_wrap(w_h_wrap), .o_active(w_h_act), .o_sync(w_h_sync)
  );

  hdmi_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .CNT_W(CNT_W)
  ) u_v_cnt (
    .clk(clk), .rst(rst), .i_clear(!w_running), .i_advance(w_running && w_h_wrap),
    .o_count(w_v), .o_wrap(w_v_wrap), .o_active(w_v_act), .o_sync(w_v_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (enable) w_state_nxt = RUN;
      RUN:      if (!enable) w_state_nxt = STOPPING;
      STOPPING: begin
        if (enable)
          w_state_nxt = RUN;
        else if (w_h_wrap && w_v_wrap)
          w_state_nxt = IDLE;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Syncs are forced inactive on the edge that drops into IDLE, whatever the porch sizes.
  assign w_emit    = w_running && (w_state_nxt != IDLE);
  assign w_active  = w_running && w_h_act && w_v_act;
  assign w_miss    = w_active && !pix_valid;
  assign pix_ready = w_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync     <= ~HS_POL;
      r_vsync     <= ~VS_POL;
      r_de        <= 1'b0;
      r_rgb       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_fs        <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_hsync <= (w_emit && w_h_sync) ? HS_POL : ~HS_POL;
      r_vsync <= (w_emit && w_v_sync) ? VS_POL : ~VS_POL;
      r_de    <= w_active;
      r_x     <= w_h;
      r_y     <= w_v;
      r_fs    <= w_active && (w_h == '0) && (w_v == '0);
      if (!w_active)
        r_rgb <= '0;
      else if (pix_valid)
        r_rgb <= pix_in;
      else
        r_rgb <= UNDERFLOW_RGB;
      if (w_miss)
        r_underflow <= 1'b1;
      else if (underflow_clr)
        r_underflow <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb         = r_rgb;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_fs;
  assign underflow   = r_underflow;

endmodule
